// File: rtl/car_light_cmd_encoder_pkg.sv
// Shared definitions for the driver-side light command path: command codes,
// button bit positions, light state encoding and the board clock rate.
package car_light_cmd_encoder_pkg;

  localparam int unsigned CLK_HZ = 12_000_000;

  localparam logic [3:0] CMD_IDLE   = 4'b0000;
  localparam logic [3:0] CMD_LEFT   = 4'b1000;
  localparam logic [3:0] CMD_RIGHT  = 4'b0001;
  localparam logic [3:0] CMD_HAZARD = 4'b0100;
  localparam logic [3:0] CMD_BRAKE  = 4'b0010;

  localparam int BTN_LEFT   = 3;
  localparam int BTN_HAZARD = 2;
  localparam int BTN_BRAKE  = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_HAZARD
  } light_state_t;

  function automatic logic [3:0] state_cmd(input light_state_t s);
    logic [3:0] cmd;
    case (s)
      ST_LEFT:   cmd = CMD_LEFT;
      ST_RIGHT:  cmd = CMD_RIGHT;
      ST_HAZARD: cmd = CMD_HAZARD;
      default:   cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

  function automatic logic is_turn(input light_state_t s);
    return (s == ST_LEFT) || (s == ST_RIGHT);
  endfunction

endpackage

// File: rtl/car_light_cmd_encoder_btn_debounce.sv
// Single raw button: two-flop synchroniser, counting debouncer and a one-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 240000,
  parameter int CNT_W      = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Any sample that agrees with the current level restarts the hold count,
  // so only an uninterrupted run of DEB_CYCLES differing samples flips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      press <= 1'b0;
      count <= '0;
    end else begin
      press <= 1'b0;
      if (sync_b == level) begin
        count <= '0;
      end else if (count == DEB_LAST) begin
        level <= sync_b;
        press <= sync_b;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/car_light_cmd_encoder.sv
// Turns four debounced buttons into the one-hot tail-light command, with
// latched turn/hazard state, turn self-cancel and a brake override.
module car_light_cmd_encoder
  import car_light_cmd_encoder_pkg::*;
#(
  parameter int DEB_CYCLES   = int'(CLK_HZ / 50),
  parameter int TURN_TIMEOUT = int'(CLK_HZ * 10),
  parameter int CNT_W        = 27
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  output logic [3:0] Switch,
  output logic       CmdChg
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TURN_TIMEOUT - 1);

  logic [3:0]       level;
  logic [3:0]       press;
  light_state_t     state;
  light_state_t     state_next;
  logic [CNT_W-1:0] turn_timer;
  logic [CNT_W-1:0] timer_next;
  logic [3:0]       switch_next;
  logic             press_left;
  logic             press_right;
  logic             press_hazard;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk  (CLK),
      .rst  (RST),
      .raw  (BTN[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  // Only the brake level and the three latching presses drive the command.
  logic unused_btn_bits;
  assign unused_btn_bits = ^{level[BTN_LEFT], level[BTN_HAZARD], level[BTN_RIGHT],
                             press[BTN_BRAKE]};

  assign press_left   = press[BTN_LEFT];
  assign press_right  = press[BTN_RIGHT];
  assign press_hazard = press[BTN_HAZARD];

  // Hazard outranks turns; a simultaneous left+right press is treated as noise.
  always_comb begin
    state_next = state;
    if (press_hazard) begin
      state_next = (state == ST_HAZARD) ? ST_IDLE : ST_HAZARD;
    end else if (press_left && !press_right) begin
      case (state)
        ST_LEFT:   state_next = ST_IDLE;
        ST_HAZARD: state_next = ST_HAZARD;
        default:   state_next = ST_LEFT;
      endcase
    end else if (press_right && !press_left) begin
      case (state)
        ST_RIGHT:  state_next = ST_IDLE;
        ST_HAZARD: state_next = ST_HAZARD;
        default:   state_next = ST_RIGHT;
      endcase
    end

    if ((state_next == state) && is_turn(state) && (turn_timer == TIMEOUT_LAST)) begin
      state_next = ST_IDLE;
    end

    if (!is_turn(state_next) || (state_next != state)) begin
      timer_next = '0;
    end else begin
      timer_next = turn_timer + CNT_W'(1);
    end

    switch_next = level[BTN_BRAKE] ? CMD_BRAKE : state_cmd(state_next);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      turn_timer <= '0;
      Switch     <= CMD_IDLE;
      CmdChg     <= 1'b0;
    end else begin
      state      <= state_next;
      turn_timer <= timer_next;
      Switch     <= switch_next;
      CmdChg     <= (switch_next != Switch);
    end
  end

endmodule

// File: tb/tb_car_light_cmd_encoder.sv
// Directed bench for car_light_cmd_encoder with a window-based behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_car_light_cmd_encoder;

  localparam int DEB  = 4;
  localparam int TO   = 50;
  localparam int HIST = DEB + 2;

  localparam int M_IDLE  = 0;
  localparam int M_LEFT  = 1;
  localparam int M_RIGHT = 2;
  localparam int M_HAZ   = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN = 4'b0000;
  logic [3:0] Switch;
  logic       CmdChg;

  int checks   = 0;
  int failures = 0;

  int            m_state = M_IDLE;
  int            m_edge  = 0;
  int            m_entry = 0;
  bit [HIST-1:0] m_hist [4];
  bit            m_lvl  [4];
  bit            m_rose [4];
  logic [3:0]    exp_sw  = 4'b0000;
  logic          exp_chg = 1'b0;

  car_light_cmd_encoder #(
    .DEB_CYCLES  (DEB),
    .TURN_TIMEOUT(TO),
    .CNT_W       (27)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN),
    .Switch(Switch),
    .CmdChg(CmdChg)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] code(input int s);
    case (s)
      M_LEFT:  return 4'b1000;
      M_RIGHT: return 4'b0001;
      M_HAZ:   return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_edge  = 0;
    m_entry = 0;
    exp_sw  = 4'b0000;
    exp_chg = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = '0;
      m_lvl[b]  = 1'b0;
      m_rose[b] = 1'b0;
    end
  endtask

  // A debounced level flips once the last DEB synchronised samples (two edges
  // old) all disagree with it; rising flips are presses used on the next edge.
  task automatic model_step();
    int         nst;
    bit         lp;
    bit         rp;
    bit         hp;
    bit         all_diff;
    logic [3:0] sw;
    m_edge++;
    lp  = m_rose[3];
    hp  = m_rose[2];
    rp  = m_rose[0];
    nst = m_state;
    if (hp) begin
      nst = (m_state == M_HAZ) ? M_IDLE : M_HAZ;
    end else if (lp && !rp) begin
      if (m_state == M_LEFT) nst = M_IDLE;
      else if (m_state != M_HAZ) nst = M_LEFT;
    end else if (rp && !lp) begin
      if (m_state == M_RIGHT) nst = M_IDLE;
      else if (m_state != M_HAZ) nst = M_RIGHT;
    end
    if (nst == m_state && (m_state == M_LEFT || m_state == M_RIGHT) &&
        (m_edge - m_entry) == TO) begin
      nst = M_IDLE;
    end
    if ((nst == M_LEFT || nst == M_RIGHT) && nst != m_state) m_entry = m_edge;
    m_state = nst;
    sw      = m_lvl[1] ? 4'b0010 : code(m_state);
    exp_chg = (sw != exp_sw);
    exp_sw  = sw;
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = {m_hist[b][HIST-2:0], BTN[b]};
      m_rose[b] = 1'b0;
      all_diff  = 1'b1;
      for (int j = 2; j < HIST; j++) begin
        if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_lvl[b]  = !m_lvl[b];
        m_rose[b] = m_lvl[b];
      end
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else model_step();
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      checkOutput("model_switch", Switch, exp_sw);
      checkOutput("model_cmdchg", {3'b000, CmdChg}, {3'b000, exp_chg});
      checkOutput("onehot", {3'b000, ($countones(Switch) > 1)}, 4'b0000);
    end
  end

  task automatic applyStimulus(input logic [3:0] value, input int cycles);
    BTN = value;
    repeat (cycles) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    checkOutput("reset_switch", Switch, 4'b0000);
    checkOutput("reset_cmdchg", {3'b000, CmdChg}, 4'b0000);
    RST = 1'b0;
    applyStimulus(4'b0000, 4);

    applyStimulus(4'b1000, 3);
    applyStimulus(4'b0000, 10);
    checkOutput("glitch_ignored", Switch, 4'b0000);

    applyStimulus(4'b1000, 6);
    checkOutput("left_before", Switch, 4'b0000);
    applyStimulus(4'b1000, 1);
    checkOutput("left_switch", Switch, 4'b1000);
    checkOutput("left_cmdchg", {3'b000, CmdChg}, 4'b0001);
    applyStimulus(4'b1000, 1);
    checkOutput("left_cmdchg_once", {3'b000, CmdChg}, 4'b0000);
    applyStimulus(4'b0000, 8);

    applyStimulus(4'b0001, 7);
    checkOutput("left_to_right", Switch, 4'b0001);
    checkOutput("right_cmdchg", {3'b000, CmdChg}, 4'b0001);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0001, 7);
    checkOutput("right_cancel", Switch, 4'b0000);
    applyStimulus(4'b0000, 8);

    applyStimulus(4'b1000, 7);
    checkOutput("timeout_enter", Switch, 4'b1000);
    applyStimulus(4'b0000, 49);
    checkOutput("timeout_minus1", Switch, 4'b1000);
    applyStimulus(4'b0000, 1);
    checkOutput("timeout_idle", Switch, 4'b0000);
    checkOutput("timeout_cmdchg", {3'b000, CmdChg}, 4'b0001);

    applyStimulus(4'b0100, 7);
    checkOutput("hazard_on", Switch, 4'b0100);
    applyStimulus(4'b0000, 210);
    checkOutput("hazard_persist", Switch, 4'b0100);
    applyStimulus(4'b0100, 7);
    checkOutput("hazard_off", Switch, 4'b0000);
    applyStimulus(4'b0000, 8);

    applyStimulus(4'b0001, 7);
    checkOutput("brake_right", Switch, 4'b0001);
    applyStimulus(4'b0010, 7);
    checkOutput("brake_override", Switch, 4'b0010);
    applyStimulus(4'b0010, 3);
    applyStimulus(4'b0000, 7);
    checkOutput("brake_release", Switch, 4'b0001);
    applyStimulus(4'b0000, 33);
    checkOutput("brake_then_timeout", Switch, 4'b0000);

    applyStimulus(4'b0001, 7);
    checkOutput("brake2_right", Switch, 4'b0001);
    applyStimulus(4'b0010, 60);
    checkOutput("brake_across_timeout", Switch, 4'b0010);
    applyStimulus(4'b0000, 7);
    checkOutput("brake_after_timeout", Switch, 4'b0000);
    checkOutput("brake_after_cmdchg", {3'b000, CmdChg}, 4'b0001);

    applyStimulus(4'b1001, 10);
    checkOutput("left_right_ignored", Switch, 4'b0000);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b1100, 7);
    checkOutput("left_hazard", Switch, 4'b0100);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0100, 7);
    checkOutput("hazard_off2", Switch, 4'b0000);
    applyStimulus(4'b0000, 8);

    applyStimulus(4'b1000, 7);
    checkOutput("pre_reset_left", Switch, 4'b1000);
    applyStimulus(4'b0000, 4);
    #2 RST = 1'b1;
    #1;
    checkOutput("async_reset_switch", Switch, 4'b0000);
    checkOutput("async_reset_cmdchg", {3'b000, CmdChg}, 4'b0000);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    applyStimulus(4'b0000, 10);
    checkOutput("post_reset_idle", Switch, 4'b0000);
    applyStimulus(4'b1000, 7);
    checkOutput("post_reset_left", Switch, 4'b1000);
    applyStimulus(4'b0000, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
